// File: rtl/etapa_mem.sv
// Vector memory stage: ALU passthrough or a single load/store over a req/ack port.
// Define MEM_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without ack.
//
// state  | meaning
// IDLE   | accepting instructions; ALU ops retire in one cycle
// ACCESS | memory transaction outstanding, waiting for mem_ack
module etapa_mem #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  input  logic [1:0]        mem_op,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       data1_in,
  input  logic [7:0]        inmediate_in,
  input  logic [2:0]        dir_dest_in,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [31:0]       wb_data,
  output logic [2:0]        wb_dest,
  output logic              mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [2:0]          dest_q, dest_d;
  logic                wb_valid_q, wb_valid_d;
  logic                wb_we_q, wb_we_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic [2:0]          wb_dest_q, wb_dest_d;
  logic                is_mem_op;
  logic                timeout_hit;
  logic [ADDR_W+7:0]   imm_ext;

  // Zero-extend then keep the low ADDR_W bits: covers both wider and narrower address buses.
  assign imm_ext   = {{ADDR_W{1'b0}}, inmediate_in};
  assign is_mem_op = (mem_op == 2'b01) || (mem_op == 2'b10);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             mem_err_q;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      cnt_q <= cnt_q + 1'b1;
      if (!mem_ack && timeout_hit) mem_err_q <= 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign mem_err = mem_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
  assign mem_err            = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dest_d      = dest_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_data_d   = wb_data_q;
    wb_dest_d   = wb_dest_q;
    stall_out   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (is_mem_op) begin
            stall_out   = 1'b1;
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = mem_op[1];
            mem_addr_d  = imm_ext[ADDR_W-1:0];
            mem_wdata_d = data1_in;
            dest_d      = dir_dest_in;
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b1;
            wb_data_d  = alu_result_in;
            wb_dest_d  = dir_dest_in;
          end
        end
      end
      ACCESS: begin
        stall_out = !mem_ack && !timeout_hit;
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_we_d    = !mem_we_q;
          wb_dest_d  = dest_q;
          if (!mem_we_q) wb_data_d = mem_rdata;
        end else if (timeout_hit) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_dest_d  = dest_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dest_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_data_q   <= '0;
      wb_dest_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dest_q      <= dest_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_data_q   <= wb_data_d;
      wb_dest_q   <= wb_dest_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_data   = wb_data_q;
  assign wb_dest   = wb_dest_q;

endmodule

// File: tb/tb_etapa_mem.sv
// Scoreboard bench for etapa_mem: expected writebacks are queued at issue and
// checked by a monitor; each task also checks its own handshake timing.
module tb_etapa_mem;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [1:0]  mem_op = 2'b00;
  logic [31:0] alu_result_in = '0;
  logic [31:0] data1_in = '0;
  logic [7:0]  inmediate_in = '0;
  logic [2:0]  dir_dest_in = '0;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        wb_valid;
  logic        wb_we;
  logic [31:0] wb_data;
  logic [2:0]  wb_dest;
  logic        mem_err;

  typedef struct {
    logic        we;
    logic [31:0] data;
    logic [2:0]  dest;
  } wb_t;

  wb_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  etapa_mem #(.ADDR_W(8), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .mem_op(mem_op),
    .alu_result_in(alu_result_in), .data1_in(data1_in), .inmediate_in(inmediate_in),
    .dir_dest_in(dir_dest_in), .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_data(wb_data), .wb_dest(wb_dest), .mem_err(mem_err)
  );

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && wb_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got we=%b data=%h dest=%0d with nothing expected",
                 wb_we, wb_data, wb_dest);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if ({wb_we, wb_data, wb_dest} !== {e.we, e.data, e.dest}) begin
          n_err++;
          $display("FAIL sb_wb: got we=%b data=%h dest=%0d expected we=%b data=%h dest=%0d",
                   wb_we, wb_data, wb_dest, e.we, e.data, e.dest);
        end
      end
    end
  end

  function automatic wb_t mk(input logic we, input logic [31:0] d, input logic [2:0] r);
    wb_t w;
    w.we = we; w.data = d; w.dest = r;
    return w;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic present(input logic [1:0] op, input logic [31:0] alu, input logic [31:0] d1,
                         input logic [7:0] imm, input logic [2:0] dest);
    valid_in = 1'b1; mem_op = op; alu_result_in = alu; data1_in = d1;
    inmediate_in = imm; dir_dest_in = dest;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({stall_out, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_we, wb_data, wb_dest, mem_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h wbv=%b wbwe=%b wbd=%h dest=%0d err=%b expected all 0",
               mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_we, wb_data, wb_dest, mem_err);
    end
    step(); reset_n = 1'b1; step();
  endtask

  task automatic test_alu();
    exp_q.push_back(mk(1'b1, 32'h11223344, 3'd5));
    present(2'b00, 32'h11223344, 32'h0, 8'h00, 3'd5);
    @(negedge clk);
    n_cmp++;
    if (stall_out !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %b expected 0", stall_out); end
    step(); valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({wb_valid, wb_we, wb_data, wb_dest} !== {1'b1, 1'b1, 32'h11223344, 3'd5}) begin
      n_err++;
      $display("FAIL alu_latency: got v=%b we=%b data=%h dest=%0d expected v=1 we=1 data=11223344 dest=5",
               wb_valid, wb_we, wb_data, wb_dest);
    end
    step();
  endtask

  task automatic test_load();
    exp_q.push_back(mk(1'b1, 32'hDEADBEEF, 3'd3));
    present(2'b01, 32'h0, 32'h0, 8'h2A, 3'd3);
    @(negedge clk);
    n_cmp++;
    if (stall_out !== 1'b1) begin n_err++; $display("FAIL load_stall_idle: got %b expected 1", stall_out); end
    step();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; end
      @(negedge clk);
      n_cmp++;
      if ({mem_req, mem_we, mem_addr, stall_out} !== {1'b1, 1'b0, 8'h2A, (i != 2)}) begin
        n_err++;
        $display("FAIL load_access[%0d]: got req=%b we=%b addr=%h stall=%b expected req=1 we=0 addr=2a stall=%b",
                 i, mem_req, mem_we, mem_addr, stall_out, (i != 2));
      end
      step();
    end
    mem_ack = 1'b0; mem_rdata = 32'h0; valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, wb_valid, wb_we, wb_data, wb_dest} !== {1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 3'd3}) begin
      n_err++;
      $display("FAIL load_wb: got req=%b v=%b we=%b data=%h dest=%0d expected req=0 v=1 we=1 data=deadbeef dest=3",
               mem_req, wb_valid, wb_we, wb_data, wb_dest);
    end
    step();
  endtask

  task automatic test_store();
    exp_q.push_back(mk(1'b0, 32'hDEADBEEF, 3'd6));
    present(2'b10, 32'h0, 32'hA5A5A5A5, 8'h10, 3'd6);
    step();
    mem_ack = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, stall_out} !== {1'b1, 1'b1, 8'h10, 32'hA5A5A5A5, 1'b0}) begin
      n_err++;
      $display("FAIL store_access: got req=%b we=%b addr=%h wdata=%h stall=%b expected req=1 we=1 addr=10 wdata=a5a5a5a5 stall=0",
               mem_req, mem_we, mem_addr, mem_wdata, stall_out);
    end
    step(); mem_ack = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({wb_valid, wb_we, wb_data, wb_dest} !== {1'b1, 1'b0, 32'hDEADBEEF, 3'd6}) begin
      n_err++;
      $display("FAIL store_wb: got v=%b we=%b data=%h dest=%0d expected v=1 we=0 data=deadbeef dest=6",
               wb_valid, wb_we, wb_data, wb_dest);
    end
    step();
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(mk(1'b1, 32'h01020304, 3'd1));
    exp_q.push_back(mk(1'b1, 32'hCAFEF00D, 3'd2));
    present(2'b01, 32'h0, 32'h0, 8'h05, 3'd1);
    step();
    @(negedge clk);
    n_cmp++;
    if (stall_out !== 1'b1) begin n_err++; $display("FAIL b2b_stall: got %b expected 1", stall_out); end
    step();
    mem_ack = 1'b1; mem_rdata = 32'h01020304;
    step();
    mem_ack = 1'b0;
    present(2'b00, 32'hCAFEF00D, 32'h0, 8'h00, 3'd2);
    @(negedge clk);
    n_cmp++;
    if ({wb_valid, wb_dest, stall_out} !== {1'b1, 3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_load_wb: got v=%b dest=%0d stall=%b expected v=1 dest=1 stall=0", wb_valid, wb_dest, stall_out);
    end
    step(); valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({wb_valid, wb_dest, wb_data} !== {1'b1, 3'd2, 32'hCAFEF00D}) begin
      n_err++;
      $display("FAIL b2b_alu_wb: got v=%b dest=%0d data=%h expected v=1 dest=2 data=cafef00d", wb_valid, wb_dest, wb_data);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (wb_valid !== 1'b0) begin n_err++; $display("FAIL b2b_duplicate: got wb_valid=%b expected 0", wb_valid); end
    step();
  endtask

  task automatic test_spurious_ack();
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    @(negedge clk);
    step(); mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({wb_valid, wb_we, wb_data, wb_dest, mem_req, stall_out} !== {1'b0, 1'b0, 32'hCAFEF00D, 3'd2, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL spurious_ack: got v=%b we=%b data=%h dest=%0d req=%b stall=%b expected v=0 we=0 data=cafef00d dest=2 req=0 stall=0",
               wb_valid, wb_we, wb_data, wb_dest, mem_req, stall_out);
    end
    step();
  endtask

  task automatic test_reset_mid_access();
    present(2'b01, 32'h0, 32'h0, 8'h33, 3'd5);
    step(); valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1) begin n_err++; $display("FAIL rst_pre_req: got %b expected 1", mem_req); end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, mem_addr, wb_valid, wb_we, wb_data, wb_dest, mem_err} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_access: got req=%b addr=%h v=%b we=%b data=%h dest=%0d err=%b expected all 0",
               mem_req, mem_addr, wb_valid, wb_we, wb_data, wb_dest, mem_err);
    end
    step(); reset_n = 1'b1; step();
    exp_q.push_back(mk(1'b1, 32'h55AA55AA, 3'd7));
    present(2'b00, 32'h55AA55AA, 32'h0, 8'h00, 3'd7);
    step(); valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({wb_valid, wb_data, wb_dest} !== {1'b1, 32'h55AA55AA, 3'd7}) begin
      n_err++;
      $display("FAIL rst_recover: got v=%b data=%h dest=%0d expected v=1 data=55aa55aa dest=7", wb_valid, wb_data, wb_dest);
    end
    step();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    exp_q.push_back(mk(1'b0, 32'h55AA55AA, 3'd4));
    present(2'b01, 32'h0, 32'h0, 8'h07, 3'd4);
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_req, stall_out} !== {1'b1, (i != 3)}) begin
        n_err++;
        $display("FAIL timeout_access[%0d]: got req=%b stall=%b expected req=1 stall=%b", i, mem_req, stall_out, (i != 3));
      end
      step();
    end
    valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_err, wb_valid, wb_we} !== {1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL timeout_abort: got req=%b err=%b v=%b we=%b expected req=0 err=1 v=1 we=0", mem_req, mem_err, wb_valid, wb_we);
    end
    step();
    exp_q.push_back(mk(1'b1, 32'h0BADF00D, 3'd0));
    present(2'b00, 32'h0BADF00D, 32'h0, 8'h00, 3'd0);
    step(); valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_err !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got mem_err=%b expected 1", mem_err); end
    step();
  endtask
`else
  task automatic test_no_timeout();
    present(2'b01, 32'h0, 32'h0, 8'h07, 3'd4);
    step(); valid_in = 1'b0;
    repeat (20) step();
    @(negedge clk);
    n_cmp++;
    if ({mem_req, stall_out, mem_err} !== {1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL no_timeout: got req=%b stall=%b err=%b expected req=1 stall=1 err=0", mem_req, stall_out, mem_err);
    end
    exp_q.push_back(mk(1'b1, 32'h76543210, 3'd4));
    step(); mem_ack = 1'b1; mem_rdata = 32'h76543210;
    step(); mem_ack = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    repeat (2) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending writebacks expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/etapa_mem.md
Name: etapa_mem

Overview:
Vector memory stage directly downstream of the execute stage.
- Consumes the 32-bit, 4-lane ALU result, the first-operand vector, the destination register address and the 8-bit immediate.
- Performs vector load/store through a req/ack data-memory handshake, stalling upstream while a transaction is outstanding.
- Registers writeback data, destination and write-enable for the WB stage.

Parameters:
ADDR_W, 8, data-memory word address width; the immediate is zero-extended or truncated to ADDR_W.
TIMEOUT_CYC, 16, ACCESS cycles without ack before abort; used only with MEM_TIMEOUT_EN.

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
valid_in  in  1  execute stage presents a valid instruction
mem_op  in  2  00 ALU passthrough, 01 vector load, 10 vector store, 11 treated as 00
alu_result_in  in  32  execute-stage ALU result (4 lanes x 8 bits)
data1_in  in  32  first-operand vector from execute stage; this is the store data
inmediate_in  in  8  memory word address
dir_dest_in  in  3  destination vector register
stall_out  out  1  upstream must hold its outputs this cycle
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = store, 0 = load
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  store data
mem_rdata  in  32  load data, valid when mem_ack=1
mem_ack  in  1  one-cycle acknowledge
wb_valid  out  1  writeback slot valid
wb_we  out  1  register-file write enable
wb_data  out  32  writeback vector
wb_dest  out  3  writeback register address
mem_err  out  1  sticky timeout flag; constant 0 without MEM_TIMEOUT_EN

Behaviour:
Reset
- All outputs 0: wb_*, mem_req, mem_we, mem_addr, mem_wdata, mem_err.
- State goes to IDLE immediately and asynchronously.
- Reset during ACCESS drops mem_req at once; the in-flight transaction is discarded and no writeback occurs.

FSM states: IDLE, ACCESS.

IDLE, valid_in=1, mem_op in {00, 11}
- Next edge: wb_valid=1, wb_we=1, wb_data=alu_result_in, wb_dest=dir_dest_in.
- Latency 1 cycle; stall_out=0.

IDLE, valid_in=1, mem_op in {01, 10}
- stall_out=1, combinational.
- Next edge: go to ACCESS; mem_req=1; mem_we=(mem_op==10); mem_addr=inmediate_in; mem_wdata=data1_in; dest latched internally; wb_valid=0.

IDLE, valid_in=0
- Next edge: wb_valid=0, wb_we=0; wb_data and wb_dest hold.

ACCESS
- stall_out = !mem_ack. mem_req, mem_we, mem_addr and mem_wdata are held stable.
- On the edge where mem_ack=1: mem_req=0, wb_valid=1, wb_dest=latched dest, state to IDLE.
  - Load: wb_we=1, wb_data=mem_rdata.
  - Store: wb_we=0, wb_data holds.
- Upstream advances on that same edge because stall_out=0. Minimum memory-op latency is 2 cycles.
- valid_in is ignored while in ACCESS.

Other rules
- mem_ack while in IDLE is ignored.
- stall_out=0 always means the presented instruction is consumed on the next edge.
- Widths: data paths are exactly 32 bits; no lane arithmetic in this stage.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter is cleared on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYC-1 without ack, stall_out=0 for that cycle.
  - On the next edge: mem_req=0, mem_err=1 (sticky until reset), wb_valid=1, wb_we=0, state to IDLE.
  - An ack arriving in the timeout cycle takes priority as a normal completion.
- Undefined: no counter; ACCESS waits indefinitely; mem_err tied to 0.

Test Plan:
Reset
- reset_n=0 mid-ACCESS with mem_req=1 -> mem_req=0 immediately, all wb_* = 0, state IDLE; after release, an ALU op completes normally.

ALU passthrough
- valid_in=1, mem_op=00, alu_result_in=0x11223344, dir_dest_in=5 -> next cycle wb_valid=1, wb_we=1, wb_data=0x11223344, wb_dest=5, stall_out never 1.

Load with wait states
- mem_op=01, inmediate_in=0x2A, dir_dest_in=3, ack after 3 cycles with mem_rdata=0xDEADBEEF -> mem_req=1 and mem_addr=0x2A held 3 cycles, stall_out=1 until the ack cycle, then wb_data=0xDEADBEEF, wb_we=1, wb_dest=3.

Store
- mem_op=10, data1_in=0xA5A5A5A5, immediate ack -> mem_we=1, mem_wdata=0xA5A5A5A5, 2-cycle latency, wb_valid=1, wb_we=0.

Back-to-back traffic
- Load, then ALU op presented and held during the stall -> ALU result appears exactly one cycle after the load writeback; no instruction lost or duplicated.
- Spurious mem_ack in IDLE -> no output change.

Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYC=4)
- Load with no ack -> after 4 ACCESS cycles: mem_req=0, mem_err=1, wb_valid=1, wb_we=0.
- mem_err stays 1 across later ops until reset.
